draw_arbiter: RTL
=================

Name: draw_arbiter

Overview:
- Frame-level scheduler that owns the single VGA memory write port.
- Sequences three drawers each frame, in order: background map, HUD, player/enemy sprite layer.
- Drives each drawer's enable, watches its done, and muxes the granted drawer's x/y/colour/write onto the VGA port.
- Sits between the game control FSM (which supplies frame_tick and redraw requests) and the map, HUD and sprite drawer modules.

Parameters:
- TIMEOUT, 17'd100000: maximum cycles any one phase may hold the grant before it is aborted. Must exceed 76801, the map's full-screen draw time.
- CW, 6: colour width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse; start of a frame draw
- map_req  in  1  pulse; request a map redraw at the next frame
- hud_req  in  1  pulse; request a HUD redraw at the next frame
- map_done, hud_done, spr_done  in  1 each  drawer finished; held high while its enable is high
- map_x, hud_x, spr_x  in  9 each  drawer x coordinate
- map_y, hud_y, spr_y  in  8 each  drawer y coordinate
- map_colour, hud_colour, spr_colour  in  CW each  drawer pixel data
- map_write, hud_write, spr_write  in  1 each  drawer write strobe
- map_enable, hud_enable, spr_enable  out  1 each  drawer enable, one-hot or all zero
- vga_x  out  9  muxed x
- vga_y  out  8  muxed y
- vga_colour  out  CW  muxed colour
- vga_write  out  1  muxed, gated write
- busy  out  1  high whenever state is not IDLE
- frame_done  out  1  one-cycle pulse when a frame sequence completes
- overrun  out  1  sticky; frame_tick arrived while busy
- timeout_err  out  3  sticky per phase: bit2 map, bit1 hud, bit0 sprite

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; all enables, frame_done, overrun and timeout_err = 0.
  - map_pend = 1 and hud_pend = 1, so the first frame paints everything.
  - Phase counter = 0.
- States: IDLE, MAP, HUD, SPR, FIN.
  - IDLE: on frame_tick go to MAP if map_pend, else HUD if hud_pend, else SPR.
  - MAP: map_enable=1. On map_done=1 or counter==TIMEOUT, clear map_pend and go to HUD if hud_pend, else SPR.
  - HUD: hud_enable=1. On hud_done=1 or timeout, clear hud_pend and go to SPR.
  - SPR: spr_enable=1. On spr_done=1 or timeout, go to FIN.
  - FIN: frame_done=1 for exactly one cycle, then IDLE.
- Enables are registered and decoded from state; an enable drops the cycle after done is seen.
- Phase counter:
  - Clears on every state change.
  - Increments each cycle in MAP, HUD or SPR.
  - Reaching TIMEOUT with done still 0 aborts the phase and sets the matching timeout_err bit.
  - A phase that completes normally does not set its bit.
- Pending requests:
  - map_req or hud_req in any state sets the corresponding pend flag.
  - A request arriving in the same cycle its pend flag is cleared wins: the flag stays 1 and the layer redraws next frame.
- Mux (combinational from state):
  - vga_x, vga_y, vga_colour come from the granted drawer.
  - vga_write = granted_write AND NOT granted_done. This suppresses the stray (0,0) write a drawer emits in its done cycle.
  - In IDLE and FIN: vga_write = 0; x, y and colour = 0.
- frame_tick while busy:
  - Ignored for sequencing; the frame is not queued.
  - Sets overrun (sticky until reset).
  - A frame_tick in the FIN cycle also counts as overrun.
- Drawer done held high from a previous grant does not affect the current phase; only the granted drawer's done is examined.
- Reset mid-phase: all enables drop immediately (asynchronous); the next frame redraws map and HUD.

Test Plan:
- Post-reset frame: release reset, pulse frame_tick; map_done after 76801 cycles, hud_done after 200, spr_done after 50 -> enables assert in order map, hud, spr; exactly one frame_done pulse; busy high throughout; no timeout_err.
- Steady frame: second frame_tick with no requests -> straight to SPR; map_enable and hud_enable never assert; frame_done 1 cycle after spr_done+1.
- Write gating: map asserts map_write=1 with map_done=1 at x=0,y=0 -> vga_write=0 that cycle; in all non-done cycles vga_write equals map_write and vga_x/vga_y match map_x/map_y.
- Overrun: frame_tick during HUD -> overrun=1; sequence completes unchanged; no second sequence starts.
- Timeout: TIMEOUT=17'd1000, hud_done held 0 -> hud_enable drops after 1000 cycles; timeout_err=3'b010; SPR runs; frame_done pulses.
- Request race: hud_req pulsed in the same cycle hud_done is seen -> next frame_tick enters HUD again. Async reset during SPR -> spr_enable falls without a clock edge and map_pend=1.

Source files
------------

// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - frame scheduler granting the VGA write port to map, HUD and sprite drawers
module draw_arbiter #(
  parameter logic [16:0] TIMEOUT = 17'd100000,
  parameter int          CW      = 6
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic          map_req,
  input  logic          hud_req,
  input  logic          map_done,
  input  logic          hud_done,
  input  logic          spr_done,
  input  logic [8:0]    map_x,
  input  logic [8:0]    hud_x,
  input  logic [8:0]    spr_x,
  input  logic [7:0]    map_y,
  input  logic [7:0]    hud_y,
  input  logic [7:0]    spr_y,
  input  logic [CW-1:0] map_colour,
  input  logic [CW-1:0] hud_colour,
  input  logic [CW-1:0] spr_colour,
  input  logic          map_write,
  input  logic          hud_write,
  input  logic          spr_write,
  output logic          map_enable,
  output logic          hud_enable,
  output logic          spr_enable,
  output logic [8:0]    vga_x,
  output logic [7:0]    vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_write,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun,
  output logic [2:0]    timeout_err
);

  typedef enum logic [2:0] {IDLE, MAP, HUD, SPR, FIN} state_t;

  state_t        state, nxt;
  logic          map_pend, hud_pend;
  logic [16:0]   cnt;
  logic          g_done, g_write, expired, phase_end, in_phase;
  logic [8:0]    g_x;
  logic [7:0]    g_y;
  logic [CW-1:0] g_colour;

  // Only the granted drawer is visible; stale done lines of other drawers are ignored.
  always_comb begin
    g_done   = 1'b0;
    g_write  = 1'b0;
    g_x      = '0;
    g_y      = '0;
    g_colour = '0;
    case (state)
      MAP: begin g_done = map_done; g_write = map_write; g_x = map_x; g_y = map_y; g_colour = map_colour; end
      HUD: begin g_done = hud_done; g_write = hud_write; g_x = hud_x; g_y = hud_y; g_colour = hud_colour; end
      SPR: begin g_done = spr_done; g_write = spr_write; g_x = spr_x; g_y = spr_y; g_colour = spr_colour; end
      default: ;
    endcase
  end

  assign in_phase   = (state == MAP) || (state == HUD) || (state == SPR);
  assign expired    = (cnt == TIMEOUT);
  assign phase_end  = g_done || expired;
  assign vga_x      = g_x;
  assign vga_y      = g_y;
  assign vga_colour = g_colour;
  assign vga_write  = g_write && !g_done;
  assign busy       = (state != IDLE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (frame_tick) nxt = map_pend ? MAP : (hud_pend ? HUD : SPR);
      MAP:  if (phase_end)  nxt = hud_pend ? HUD : SPR;
      HUD:  if (phase_end)  nxt = SPR;
      SPR:  if (phase_end)  nxt = FIN;
      FIN:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      map_enable  <= 1'b0;
      hud_enable  <= 1'b0;
      spr_enable  <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 3'b000;
      map_pend    <= 1'b1;
      hud_pend    <= 1'b1;
      cnt         <= '0;
    end else begin
      state      <= nxt;
      map_enable <= (nxt == MAP);
      hud_enable <= (nxt == HUD);
      spr_enable <= (nxt == SPR);
      frame_done <= (nxt == FIN);

      if (nxt != state)  cnt <= '0;
      else if (in_phase) cnt <= cnt + 17'd1;

      if (frame_tick && state != IDLE) overrun <= 1'b1;

      if (in_phase && expired && !g_done) begin
        case (state)
          MAP:     timeout_err[2] <= 1'b1;
          HUD:     timeout_err[1] <= 1'b1;
          default: timeout_err[0] <= 1'b1;
        endcase
      end

      // A request landing on the clearing cycle keeps the flag set.
      if (state == MAP && nxt != MAP) map_pend <= map_req;
      else if (map_req)               map_pend <= 1'b1;
      if (state == HUD && nxt != HUD) hud_pend <= hud_req;
      else if (hud_req)               hud_pend <= 1'b1;
    end
  end

endmodule
